// File: rtl/dma_pkg.sv
// Shared definitions for the device DMA engines (read and write direction).
package dma_pkg;

    localparam int          DMA_WORD_SIZE = 16;
    localparam logic [15:0] DMA_ADDRESS   = 16'h01F4;
    localparam int          DMA_LENGTH    = 12;
    localparam int          DMA_BURST     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_SEND,
        S_DONE
    } dma_state_e;

endpackage

// File: rtl/dma_reader.sv
// Memory-to-device DMA: on cmd, acquires the BR/BG bus, reads LENGTH words in
// BURST-word reads and forwards each burst to the device, then pulses interrupt.
module dma_reader
    import dma_pkg::*;
#(
    parameter int                   WORD_SIZE = DMA_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] ADDRESS   = DMA_ADDRESS,
    parameter int                   LENGTH    = DMA_LENGTH,
    parameter int                   BURST     = DMA_BURST
) (
    input  logic                       CLK,
    input  logic                       reset_n,
    input  logic                       cmd,
    input  logic                       BG,
    output logic                       BR,
    output logic                       READ,
    output logic [WORD_SIZE-1:0]       addr,
    input  logic [BURST*WORD_SIZE-1:0] mdata,
    input  logic                       mem_ready,
    output logic [BURST*WORD_SIZE-1:0] ddata,
    output logic                       dvalid,
    input  logic                       dready,
    output logic [1:0]                 offset,
    output logic                       interrupt,
    output dma_state_e                 state_dbg
);

    localparam int         NBURST   = LENGTH / BURST;
    localparam logic [1:0] LAST_OFF = 2'(NBURST - 1);

    dma_state_e                 state_q, state_d;
    logic                       br_q, br_d;
    logic                       dvalid_q, dvalid_d;
    logic                       interrupt_q, interrupt_d;
    logic [1:0]                 offset_q, offset_d;
    logic [BURST*WORD_SIZE-1:0] buf_q, buf_d;

    logic                       last_burst;
    logic [WORD_SIZE-1:0]       rd_addr;

    assign last_burst = (offset_q == LAST_OFF);
    assign rd_addr    = ADDRESS + WORD_SIZE'(BURST) * WORD_SIZE'(offset_q);

    // The address bus is shared with the CPU: drive it only while granted and busy.
    assign READ = (state_q == S_RD) && BG;
    assign addr = (BG && (state_q != S_IDLE)) ? rd_addr : {WORD_SIZE{1'bz}};

    always_comb begin
        state_d     = state_q;
        br_d        = br_q;
        dvalid_d    = dvalid_q;
        interrupt_d = 1'b0;
        offset_d    = offset_q;
        buf_d       = buf_q;
        case (state_q)
            S_IDLE: begin
                if (cmd) begin
                    br_d    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (BG) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                // Losing the grant restarts the same burst once BG returns.
                if (!BG) begin
                    state_d = S_REQ;
                end else if (mem_ready) begin
                    buf_d    = mdata;
                    dvalid_d = 1'b1;
                    state_d  = S_SEND;
                    if (last_burst) begin
                        br_d = 1'b0;
                    end
                end
            end
            S_SEND: begin
                // Device channel: ddata is stable while dvalid=1; a burst moves
                // on the first cycle with dvalid=1 and dready=1.
                if (dready) begin
                    dvalid_d = 1'b0;
                    if (last_burst) begin
                        interrupt_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        offset_d = offset_q + 2'd1;
                        state_d  = BG ? S_RD : S_REQ;
                    end
                end
            end
            S_DONE: begin
                offset_d = 2'd0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            br_q        <= 1'b0;
            dvalid_q    <= 1'b0;
            interrupt_q <= 1'b0;
            offset_q    <= 2'd0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            br_q        <= br_d;
            dvalid_q    <= dvalid_d;
            interrupt_q <= interrupt_d;
            offset_q    <= offset_d;
            buf_q       <= buf_d;
        end
    end

    assign BR        = br_q;
    assign dvalid    = dvalid_q;
    assign interrupt = interrupt_q;
    assign offset    = offset_q;
    assign ddata     = buf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dma_reader.sv
// Bench for dma_reader: cycle table for the basic transfer, then bus/memory/device
// models with directed and random delays checked against a transfer-level model.
module tb_dma_reader;
    import dma_pkg::*;

    localparam int W  = DMA_WORD_SIZE;
    localparam int BW = DMA_BURST * DMA_WORD_SIZE;
    localparam int NB = DMA_LENGTH / DMA_BURST;

    logic          CLK = 1'b0;
    logic          reset_n, cmd, BG, mem_ready, dready;
    logic [BW-1:0] mdata;
    wire  [W-1:0]  addr;
    logic          BR, READ, dvalid, interrupt;
    logic [BW-1:0] ddata;
    logic [1:0]    offset;
    dma_state_e    state_dbg;

    dma_reader dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .cmd       (cmd),
        .BG        (BG),
        .BR        (BR),
        .READ      (READ),
        .addr      (addr),
        .mdata     (mdata),
        .mem_ready (mem_ready),
        .ddata     (ddata),
        .dvalid    (dvalid),
        .dready    (dready),
        .offset    (offset),
        .interrupt (interrupt),
        .state_dbg (state_dbg)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    string         cur_tag = "reset";
    logic [BW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h at %0t", cur_tag, name, got, exp, $time);
        end
    endtask

    // Memory content: word at address a is 16'hA000 + a; lane i holds word a+i.
    function automatic logic [BW-1:0] mem_burst(input logic [W-1:0] a);
        logic [BW-1:0] r;
        for (int i = 0; i < DMA_BURST; i++) r[i*W +: W] = 16'hA000 + a + W'(i);
        return r;
    endfunction

    function automatic logic [W-1:0] exp_addr(input int k);
        return DMA_ADDRESS + W'(DMA_BURST * k);
    endfunction

    // ---------------- cycle table for the basic transfer ----------------
    typedef struct {
        logic       cmd, bg, mr, dr;
        logic       br, rd, dv, irq;
        logic [1:0] off;
        logic [W-1:0] a;
    } vec_t;

    vec_t tbl[10];

    task automatic run_table();
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h01F4};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 16'h01F8};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0000};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 16'h01FC};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 16'h0000};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'h0000};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000};
        cur_tag = "table";
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            cmd       = tbl[i].cmd;
            BG        = tbl[i].bg;
            mem_ready = tbl[i].mr;
            dready    = tbl[i].dr;
            #1;
            mdata = READ ? mem_burst(addr) : '0;
            #1;
            chk("br", BR, tbl[i].br);
            chk("read", READ, tbl[i].rd);
            chk("dvalid", dvalid, tbl[i].dv);
            chk("interrupt", interrupt, tbl[i].irq);
            chk("offset", offset, tbl[i].off);
            if (tbl[i].rd) chk("addr", addr, tbl[i].a);
            if (tbl[i].dv) chk("ddata", ddata, mem_burst(exp_addr(int'(tbl[i].off))));
        end
        chk("state_idle", state_dbg, S_IDLE);
    endtask

    // ---------------- environment: arbiter, memory, device ----------------
    int            cfg_bg_dly = 0;
    int            cfg_mem_lat = 0;
    int            cfg_dr_hold[NB] = '{0, 0, 0};
    int            cfg_drop_off = -1;
    int            cfg_cmd_again = -1;
    bit            cfg_rand_drop = 0;
    bit            cfg_cmd_noise = 0;

    int            bg_wait = 0, drop_cnt = 0, rd_cnt = 0, dr_wait = 0;
    int            cur_lat = 0, cur_dr_hold = 0;
    int            cap_n = 0, del_n = 0, irq_n = 0;
    bit            dropped = 0, busy = 0, prev_hold = 0;
    logic [BW-1:0] prev_ddata = '0;

    function automatic int pick_lat();
        return (cfg_mem_lat < 0) ? int'($urandom_range(0, 3)) : cfg_mem_lat;
    endfunction

    function automatic int pick_hold(input int n);
        if (n >= NB) return 0;
        return (cfg_dr_hold[n] < 0) ? int'($urandom_range(0, 3)) : cfg_dr_hold[n];
    endfunction

    task automatic env_cycle();
        @(negedge CLK);
        if (!BR) begin
            BG = 1'b0; bg_wait = 0;
        end else if (drop_cnt > 0) begin
            BG = 1'b0; drop_cnt--; bg_wait = 0;
        end else if (!BG) begin
            if (bg_wait >= cfg_bg_dly) BG = 1'b1;
            else bg_wait++;
        end
        #1;
        if (READ && ((cap_n == cfg_drop_off && !dropped) ||
                     (cfg_rand_drop && $urandom_range(0, 5) == 0))) begin
            dropped  = 1'b1;
            BG       = 1'b0;
            drop_cnt = cfg_rand_drop ? int'($urandom_range(1, 3)) : 2;
            bg_wait  = 0;
            #1;
            chk("read_drops_with_bg", READ, 1'b0);
        end
        if (prev_hold) begin
            chk("dvalid_held", dvalid, 1'b1);
            chk("ddata_held", ddata, prev_ddata);
        end
        if (dvalid) chk("no_read_in_send", READ, 1'b0);
        if (READ) begin
            chk("rd_addr", addr, exp_addr(cap_n));
            chk("rd_offset", offset, cap_n);
            mem_ready = (rd_cnt >= cur_lat);
            mdata     = mem_ready ? mem_burst(addr) : {$urandom, $urandom};
            if (mem_ready) begin
                cap_n++; rd_cnt = 0; cur_lat = pick_lat();
            end else begin
                rd_cnt++;
            end
        end else begin
            rd_cnt    = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mdata     = {$urandom, $urandom};
        end
        if (dvalid) begin
            chk("send_offset", offset, del_n);
            dready = (dr_wait >= cur_dr_hold);
            if (dready) begin
                chk("xfer_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("ddata", ddata, exp_q.pop_front());
                del_n++; dr_wait = 0; cur_dr_hold = pick_hold(del_n);
            end else begin
                dr_wait++;
            end
        end else begin
            dready = 1'($urandom_range(0, 1));
        end
        prev_hold  = dvalid && !dready;
        prev_ddata = ddata;
        if (interrupt) begin
            irq_n++;
            chk("irq_after_all", del_n, NB);
            busy = 1'b0;
        end
        cmd = 1'b0;
        if (busy && cfg_cmd_again >= 0 && dvalid && del_n == cfg_cmd_again) cmd = 1'b1;
        if (busy && cfg_cmd_noise && $urandom_range(0, 3) == 0) cmd = 1'b1;
    endtask

    task automatic start_model();
        exp_q.delete();
        for (int k = 0; k < NB; k++) exp_q.push_back(mem_burst(exp_addr(k)));
        cap_n = 0; del_n = 0; irq_n = 0; dropped = 1'b0;
        rd_cnt = 0; dr_wait = 0; prev_hold = 1'b0; drop_cnt = 0;
        cur_lat = pick_lat(); cur_dr_hold = pick_hold(0);
        cmd = 1'b1; busy = 1'b1;
    endtask

    task automatic set_defaults();
        cfg_bg_dly = 0; cfg_mem_lat = 0; cfg_dr_hold = '{0, 0, 0};
        cfg_drop_off = -1; cfg_cmd_again = -1; cfg_rand_drop = 0; cfg_cmd_noise = 0;
    endtask

    task automatic run_transfer(input string tag, input int exp_cycles);
        int n;
        bit got;
        cur_tag = tag;
        start_model();
        n = 0; got = 1'b0;
        while (!got && n < 400) begin
            env_cycle();
            n++;
            if (irq_n > 0) got = 1'b1;
        end
        chk("irq_seen", got, 1'b1);
        if (exp_cycles > 0) chk("cycles_to_irq", n, exp_cycles);
        repeat (3) env_cycle();
        chk("one_irq_cycle", irq_n, 1);
        chk("all_delivered", del_n, NB);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("br_idle", BR, 1'b0);
        chk("offset_idle", offset, 2'd0);
        chk("state_idle", state_dbg, S_IDLE);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n = 1'b0; cmd = 1'b0; BG = 1'b0; mem_ready = 1'b0; dready = 1'b0; mdata = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("rst_br", BR, 1'b0);
        chk("rst_read", READ, 1'b0);
        chk("rst_dvalid", dvalid, 1'b0);
        chk("rst_interrupt", interrupt, 1'b0);
        chk("rst_offset", offset, 2'd0);
        chk("rst_ddata", ddata, '0);
        chk("rst_state", state_dbg, S_IDLE);
        reset_n = 1'b1;

        run_table();

        set_defaults();
        run_transfer("basic", 8);

        set_defaults(); cfg_mem_lat = 2;
        run_transfer("mem_latency", 14);

        set_defaults(); cfg_dr_hold = '{0, 5, 0};
        run_transfer("backpressure", 13);

        set_defaults(); cfg_bg_dly = 3;
        run_transfer("bg_delay", 11);

        set_defaults(); cfg_drop_off = 2;
        run_transfer("bg_drop", -1);
        chk("bg_drop_happened", dropped, 1'b1);

        set_defaults(); cfg_cmd_again = 1;
        run_transfer("cmd_again", 8);

        // Reset while burst 1 is waiting on the device.
        set_defaults(); cfg_dr_hold = '{0, 20, 0};
        cur_tag = "reset_mid";
        begin
            int n;
            start_model();
            n = 0;
            while (!(dvalid && !dready && del_n == 1) && n < 100) begin
                env_cycle();
                n++;
            end
            chk("reached_send1", dvalid && !dready && del_n == 1, 1'b1);
            reset_n = 1'b0;
            @(posedge CLK);
            @(negedge CLK);
            #1;
            chk("abort_br", BR, 1'b0);
            chk("abort_dvalid", dvalid, 1'b0);
            chk("abort_offset", offset, 2'd0);
            chk("abort_interrupt", interrupt, 1'b0);
            chk("abort_state", state_dbg, S_IDLE);
            reset_n = 1'b1;
            busy = 1'b0; prev_hold = 1'b0; irq_n = 0;
            repeat (5) env_cycle();
            chk("no_irq_after_abort", irq_n, 0);
        end
        set_defaults();
        run_transfer("after_reset", 8);

        for (int r = 0; r < 6; r++) begin
            set_defaults();
            cfg_mem_lat   = -1;
            cfg_dr_hold   = '{-1, -1, -1};
            cfg_bg_dly    = int'($urandom_range(0, 3));
            cfg_rand_drop = 1'b1;
            cfg_cmd_noise = 1'b1;
            run_transfer($sformatf("random%0d", r), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
